// File: rtl/pong_game_ctrl_if.sv
// Bundle between the Pong match sequencer and its neighbours: the
// buttons and ball edges come in, the animation gating and scores go out.
interface pong_game_ctrl_if;
  logic        in_ani_stb;
  logic        in_button_start;
  logic        in_button_pause;
  logic [11:0] in_ball_x1;
  logic [11:0] in_ball_x2;
  logic        out_animate;
  logic        out_round_reset;
  logic [3:0]  out_score_l;
  logic [3:0]  out_score_r;
  logic        out_serve_dir;
  logic        out_winner;
  logic [2:0]  out_state;

  modport master (
    output in_ani_stb, in_button_start, in_button_pause, in_ball_x1, in_ball_x2,
    input  out_animate, out_round_reset, out_score_l, out_score_r,
           out_serve_dir, out_winner, out_state
  );

  modport slave (
    input  in_ani_stb, in_button_start, in_button_pause, in_ball_x1, in_ball_x2,
    output out_animate, out_round_reset, out_score_l, out_score_r,
           out_serve_dir, out_winner, out_state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: gates bar/ball animation, detects missed balls
// and keeps both scores through serve, play, pause, point and game over.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 639
) (
  input  logic              in_clock,
  input  logic              in_reset,
  pong_game_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [3:0]  WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0]  SERVE_VAL = 8'(SERVE_FRAMES);
  localparam logic [7:0]  POINT_VAL = 8'(POINT_FRAMES);
  localparam logic [11:0] LEFT_LIM  = 12'(LEFT_LIMIT);
  localparam logic [11:0] RIGHT_LIM = 12'(RIGHT_LIMIT);

  state_t     state, state_nx;
  logic [7:0] frame_cnt, frame_cnt_nx;
  logic [3:0] score_l, score_l_nx;
  logic [3:0] score_r, score_r_nx;
  logic       serve_dir, serve_dir_nx;
  logic       winner, winner_nx;
  logic       animate, round_reset;

  logic [1:0] start_sync, pause_sync;
  logic       start_prev, pause_prev;
  logic       start_rise, pause_rise;
  logic       left_miss, right_miss;

  // Rise pulses are registered so a press lands on the state register three edges later.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      start_sync <= '0;
      pause_sync <= '0;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      start_rise <= 1'b0;
      pause_rise <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], bus.in_button_start};
      pause_sync <= {pause_sync[0], bus.in_button_pause};
      start_prev <= start_sync[1];
      pause_prev <= pause_sync[1];
      start_rise <= start_sync[1] & ~start_prev;
      pause_rise <= pause_sync[1] & ~pause_prev;
    end
  end

  assign left_miss  = (bus.in_ball_x1 <= LEFT_LIM);
  assign right_miss = (bus.in_ball_x2 >= RIGHT_LIM);

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      score_l     <= '0;
      score_r     <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      animate     <= 1'b0;
      round_reset <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_cnt   <= frame_cnt_nx;
      score_l     <= score_l_nx;
      score_r     <= score_r_nx;
      serve_dir   <= serve_dir_nx;
      winner      <= winner_nx;
      animate     <= (state_nx == PLAY);
      round_reset <= (state_nx == SERVE) && (state != SERVE);
    end
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    score_l_nx   = score_l;
    score_r_nx   = score_r;
    serve_dir_nx = serve_dir;
    winner_nx    = winner;
    case (state)
      IDLE: begin
        if (start_rise) begin
          score_l_nx   = '0;
          score_r_nx   = '0;
          frame_cnt_nx = SERVE_VAL;
          state_nx     = SERVE;
        end
      end
      SERVE: begin
        if (bus.in_ani_stb) begin
          frame_cnt_nx = frame_cnt - 8'd1;
          if (frame_cnt == 8'd1) state_nx = PLAY;
        end
      end
      PLAY: begin
        // The left miss outranks a right miss, and any miss outranks a pause.
        if (bus.in_ani_stb && left_miss) begin
          score_r_nx   = score_r + 4'd1;
          serve_dir_nx = 1'b0;
          frame_cnt_nx = POINT_VAL;
          state_nx     = POINT;
        end else if (bus.in_ani_stb && right_miss) begin
          score_l_nx   = score_l + 4'd1;
          serve_dir_nx = 1'b1;
          frame_cnt_nx = POINT_VAL;
          state_nx     = POINT;
        end else if (pause_rise) begin
          state_nx = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_rise) state_nx = PLAY;
      end
      POINT: begin
        if (bus.in_ani_stb) begin
          frame_cnt_nx = frame_cnt - 8'd1;
          if (frame_cnt == 8'd1) begin
            if (score_l == WIN_VAL || score_r == WIN_VAL) begin
              winner_nx = (score_r == WIN_VAL);
              state_nx  = OVER;
            end else begin
              frame_cnt_nx = SERVE_VAL;
              state_nx     = SERVE;
            end
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          score_l_nx   = '0;
          score_r_nx   = '0;
          winner_nx    = 1'b0;
          frame_cnt_nx = SERVE_VAL;
          state_nx     = SERVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.out_state       = state;
  assign bus.out_animate     = animate;
  assign bus.out_round_reset = round_reset;
  assign bus.out_score_l     = score_l;
  assign bus.out_score_r     = score_r;
  assign bus.out_serve_dir   = serve_dir;
  assign bus.out_winner      = winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: walks a full match with hand-computed
// scores, states and pulse timing, including pause, double miss and async reset.
module tb_pong_game_ctrl;

  logic in_clock = 1'b0;
  logic in_reset;
  int   assert_count = 0;
  int   fail_count   = 0;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .WIN_SCORE(9), .SERVE_FRAMES(60), .POINT_FRAMES(90),
    .LEFT_LIMIT(0), .RIGHT_LIMIT(639)
  ) dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .bus(bus)
  );

  always #5 in_clock = ~in_clock;

  task automatic tick();
    @(posedge in_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic stb, input logic start, input logic pause);
    bus.in_ani_stb      = stb;
    bus.in_button_start = start;
    bus.in_button_pause = pause;
    tick();
  endtask

  task automatic runStrobes(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pressPause();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " state"},       32'(bus.out_state), 0);
    checkOutput({tag, " animate"},     32'(bus.out_animate), 0);
    checkOutput({tag, " round_reset"}, 32'(bus.out_round_reset), 0);
    checkOutput({tag, " score_l"},     32'(bus.out_score_l), 0);
    checkOutput({tag, " score_r"},     32'(bus.out_score_r), 0);
    checkOutput({tag, " serve_dir"},   32'(bus.out_serve_dir), 0);
    checkOutput({tag, " winner"},      32'(bus.out_winner), 0);
  endtask

  initial begin
    in_reset            = 1'b1;
    bus.in_ani_stb      = 1'b0;
    bus.in_button_start = 1'b0;
    bus.in_button_pause = 1'b0;
    bus.in_ball_x1      = 12'd300;
    bus.in_ball_x2      = 12'd310;
    repeat (3) tick();
    checkIdleOutputs("reset");
    in_reset = 1'b0;
    tick();

    $display("[TB] start from IDLE");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start k+2 state", 32'(bus.out_state), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start k+3 state", 32'(bus.out_state), 1);
    checkOutput("start round_reset", 32'(bus.out_round_reset), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("round_reset one cycle", 32'(bus.out_round_reset), 0);
    checkOutput("held start no repeat", 32'(bus.out_state), 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    runStrobes(59);
    checkOutput("serve after 59", 32'(bus.out_state), 1);
    checkOutput("serve animate", 32'(bus.out_animate), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("serve 60th state", 32'(bus.out_state), 2);
    checkOutput("serve 60th animate", 32'(bus.out_animate), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] left miss");
    bus.in_ball_x1 = 12'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lmiss score_r", 32'(bus.out_score_r), 1);
    checkOutput("lmiss score_l", 32'(bus.out_score_l), 0);
    checkOutput("lmiss serve_dir", 32'(bus.out_serve_dir), 0);
    checkOutput("lmiss state", 32'(bus.out_state), 4);
    checkOutput("lmiss animate", 32'(bus.out_animate), 0);
    bus.in_ball_x1 = 12'd300;
    applyStimulus(1'b0, 1'b0, 1'b0);
    runStrobes(89);
    checkOutput("point after 89", 32'(bus.out_state), 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("point 90th state", 32'(bus.out_state), 1);
    checkOutput("point 90th round_reset", 32'(bus.out_round_reset), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("point round_reset drop", 32'(bus.out_round_reset), 0);
    runStrobes(60);
    checkOutput("replay state", 32'(bus.out_state), 2);

    $display("[TB] simultaneous miss");
    bus.in_ball_x1 = 12'd0;
    bus.in_ball_x2 = 12'd639;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("both score_r", 32'(bus.out_score_r), 2);
    checkOutput("both score_l", 32'(bus.out_score_l), 0);
    checkOutput("both state", 32'(bus.out_state), 4);
    bus.in_ball_x1 = 12'd300;
    bus.in_ball_x2 = 12'd310;
    applyStimulus(1'b0, 1'b0, 1'b0);
    runStrobes(150);
    checkOutput("both replay", 32'(bus.out_state), 2);

    $display("[TB] miss with pause");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    bus.in_ball_x1 = 12'd0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("miss+pause state", 32'(bus.out_state), 4);
    checkOutput("miss+pause score_r", 32'(bus.out_score_r), 3);
    bus.in_ball_x1 = 12'd300;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pause dropped", 32'(bus.out_state), 4);
    runStrobes(150);
    checkOutput("miss+pause replay", 32'(bus.out_state), 2);

    $display("[TB] pause");
    pressPause();
    checkOutput("pause state", 32'(bus.out_state), 3);
    checkOutput("pause animate", 32'(bus.out_animate), 0);
    bus.in_ball_x1 = 12'd0;
    runStrobes(5);
    checkOutput("pause score_r", 32'(bus.out_score_r), 3);
    checkOutput("pause holds", 32'(bus.out_state), 3);
    bus.in_ball_x1 = 12'd300;
    pressPause();
    checkOutput("resume state", 32'(bus.out_state), 2);
    checkOutput("resume animate", 32'(bus.out_animate), 1);

    $display("[TB] game over");
    for (int i = 0; i < 8; i++) begin
      bus.in_ball_x2 = 12'd639;
      applyStimulus(1'b1, 1'b0, 1'b0);
      bus.in_ball_x2 = 12'd310;
      applyStimulus(1'b0, 1'b0, 1'b0);
      runStrobes(150);
    end
    checkOutput("left at 8", 32'(bus.out_score_l), 8);
    checkOutput("left at 8 state", 32'(bus.out_state), 2);
    bus.in_ball_x2 = 12'd639;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("final score_l", 32'(bus.out_score_l), 9);
    checkOutput("final serve_dir", 32'(bus.out_serve_dir), 1);
    checkOutput("final state", 32'(bus.out_state), 4);
    bus.in_ball_x2 = 12'd310;
    applyStimulus(1'b0, 1'b0, 1'b0);
    runStrobes(89);
    checkOutput("final point hold", 32'(bus.out_state), 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("over state", 32'(bus.out_state), 5);
    checkOutput("over winner", 32'(bus.out_winner), 0);
    checkOutput("over round_reset", 32'(bus.out_round_reset), 0);
    checkOutput("over score_r", 32'(bus.out_score_r), 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pressPause();
    runStrobes(3);
    checkOutput("over ignores pause", 32'(bus.out_state), 5);

    $display("[TB] restart from OVER");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart k+2 state", 32'(bus.out_state), 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart state", 32'(bus.out_state), 1);
    checkOutput("restart round_reset", 32'(bus.out_round_reset), 1);
    checkOutput("restart score_l", 32'(bus.out_score_l), 0);
    checkOutput("restart score_r", 32'(bus.out_score_r), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart round_reset drop", 32'(bus.out_round_reset), 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] async reset in POINT");
    runStrobes(60);
    bus.in_ball_x2 = 12'd639;
    applyStimulus(1'b1, 1'b0, 1'b0);
    bus.in_ball_x2 = 12'd310;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre-reset state", 32'(bus.out_state), 4);
    checkOutput("pre-reset serve_dir", 32'(bus.out_serve_dir), 1);
    runStrobes(10);
    #2;
    in_reset = 1'b1;
    #1;
    checkIdleOutputs("async reset");
    @(negedge in_clock);
    in_reset = 1'b0;
    pressPause();
    runStrobes(3);
    checkOutput("pause after reset", 32'(bus.out_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match sequencer for the Pong display path: owns the game state machine that gates the `in_animate` and `in_reset` inputs of the bar and ball blocks, detects missed balls from the ball's edge coordinates, and keeps both scores. Sits between the button inputs and the bar/ball animation blocks, and runs on the same base clock and animation strobe. Scores and state feed the score/overlay renderer.

## Interface
- `WIN_SCORE`, 9: points needed to win; 1..15.
- `SERVE_FRAMES`, 60: animation strobes frozen before play starts; 1..255.
- `POINT_FRAMES`, 90: animation strobes frozen after a point; 1..255.
- `LEFT_LIMIT`, 0: ball left edge at or below this means a left miss.
- `RIGHT_LIMIT`, 639: ball right edge at or above this means a right miss.

Ports:
- `in_clock` input 1: base clock.
- `in_reset` input 1: reset, asynchronous, active-high; one clock domain only.
- `in_ani_stb` input 1: animation strobe, one `in_clock` cycle per frame.
- `in_button_start` input 1: start/restart button, raw and asynchronous.
- `in_button_pause` input 1: pause toggle button, raw and asynchronous.
- `in_ball_x1` input 12: ball left edge.
- `in_ball_x2` input 12: ball right edge.
- `out_animate` output 1: drives bar/ball `in_animate`.
- `out_round_reset` output 1: one-cycle pulse that drives bar/ball `in_reset`.
- `out_score_l` output 4: left player score.
- `out_score_r` output 4: right player score.
- `out_serve_dir` output 1: serve direction for the ball block; 0 = toward left, 1 = toward right.
- `out_winner` output 1: 0 = left, 1 = right. Valid only in OVER.
- `out_state` output 3: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.

## Operation
- Button conditioning: each button passes through a 2-flop synchronizer plus an edge flop. A rise produces a one-cycle `start_rise` / `pause_rise`. Holding a button produces no repeats.
- Frame counter: 8 bits.
  - Loaded with SERVE_FRAMES on entry to SERVE and with POINT_FRAMES on entry to POINT.
  - Decrements only on cycles where `in_ani_stb` is high.
- State transitions:
  - IDLE: on `start_rise`, clear both scores and go to SERVE.
  - SERVE: on `in_ani_stb` with counter==1, go to PLAY. The serve delay is exactly SERVE_FRAMES strobes.
  - PLAY: miss check runs only on `in_ani_stb` cycles.
    - `in_ball_x1 <= LEFT_LIMIT`: right scores, `out_serve_dir`<=0, go to POINT.
    - Otherwise `in_ball_x2 >= RIGHT_LIMIT`: left scores, `out_serve_dir`<=1, go to POINT.
    - Both true on the same strobe: the left miss wins and only the right score increments.
    - On `pause_rise` with no miss that cycle: go to PAUSE. A miss on the same cycle takes priority and the pause is dropped.
  - PAUSE: on `pause_rise`, go to PLAY. Strobes are ignored.
  - POINT: on `in_ani_stb` with counter==1:
    - If either score == WIN_SCORE: go to OVER, with `out_winner` = the scorer.
    - Otherwise go to SERVE.
  - OVER: on `start_rise`, clear scores, clear `out_winner`, and go to SERVE.
- Ignored inputs:
  - `start_rise` is ignored in SERVE, PLAY, PAUSE and POINT.
  - `pause_rise` is ignored outside PLAY and PAUSE.
- Scores:
  - 4-bit unsigned, incremented by 1.
  - A score never exceeds WIN_SCORE, because the game stops at WIN_SCORE.
- `out_animate` is 1 exactly when the state is PLAY. It is registered and asserted in the same cycle as `out_state`==2.
- `out_round_reset` is high for exactly the first cycle of every SERVE entry (from IDLE, POINT or OVER). It is low otherwise.

## Timing
- All outputs are registered.
- Reset values: state IDLE, both scores 0, frame counter 0, `out_animate` 0, `out_round_reset` 0, `out_serve_dir` 0, `out_winner` 0. Synchronizer flops are also cleared.
- Reset asserted mid-operation clears everything immediately (asynchronously). The first transition after reset release needs a fresh button rise.
- Button latency: a rise on `in_button_start` that meets setup before clock edge k appears as `start_rise` after edge k+2. The state register changes at edge k+3. `out_round_reset` and the new `out_state` are visible after edge k+3.
- Miss latency: a miss sampled on a strobe cycle updates the score, `out_state`=POINT and `out_animate`=0 at that cycle's closing edge. The bar/ball blocks therefore see no further animation strobe.
- SERVE→PLAY and POINT→next transitions occur at the closing edge of the SERVE_FRAMES-th / POINT_FRAMES-th strobe after entry.
- A strobe in the same cycle as the entry edge is not counted.

## Test plan
- Reset then start: assert `in_reset` and release it, then raise start. Expect `out_state` 0→1 three clocks later, `out_round_reset` high for 1 cycle, and `out_animate` rising on the edge closing the 60th strobe.
- Left miss: in PLAY, set `in_ball_x1`=0 on a strobe. Expect `out_score_r`=1, `out_serve_dir`=0, state 4 and `out_animate`=0 the next cycle. After 90 strobes, expect state 1 with a `out_round_reset` pulse.
- Simultaneous miss: set `in_ball_x1`=0 and `in_ball_x2`=639 on one strobe. Expect only `out_score_r` to increment. Also drive a miss and `pause_rise` together: expect POINT, not PAUSE.
- Pause: in PLAY, press pause and expect state 3 and `out_animate`=0. Keep sending strobes with a miss position and expect no score change. Press pause again and expect state 2.
- Game over: bring the left player to 8, then score one more. Expect state 5 after 90 strobes and `out_winner`=0. Press start and expect scores 0/0, state 1 and one `out_round_reset` pulse.
- Async reset mid-POINT: assert `in_reset` between clock edges. Expect immediate IDLE with all outputs 0. Pressing pause after release leaves the state at 0.
